// File: rtl/vga_pkg.sv
// Shared timing defaults, colour types and helpers for the VGA scan-out path.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_CNT_W    = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb888_t BAR_COLOURS [8] = '{
    '{8'hFF, 8'hFF, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'h00, 8'h00, 8'h00}
  };

  // Frame-buffer words are 0x00RRGGBB; the top byte carries nothing.
  function automatic rgb888_t pixel_to_rgb(input logic [31:0] pixel);
    return '{r: pixel[23:16], g: pixel[15:8], b: pixel[7:0]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus active flag and raw (active-high) sync windows.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             active,
  output logic             hsync_win,
  output logic             vsync_win,
  output logic             origin
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == CNT_W'(H_TOTAL - 1)) begin
        hc <= '0;
        if (vc == CNT_W'(V_TOTAL - 1)) vc <= '0;
        else                           vc <= vc + CNT_W'(1);
      end else begin
        hc <= hc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    active    = (hc < CNT_W'(H_ACTIVE)) && (vc < CNT_W'(V_ACTIVE));
    hsync_win = (hc >= CNT_W'(H_ACTIVE + H_FRONT)) &&
                (hc <  CNT_W'(H_ACTIVE + H_FRONT + H_SYNC));
    vsync_win = (vc >= CNT_W'(V_ACTIVE + V_FRONT)) &&
                (vc <  CNT_W'(V_ACTIVE + V_FRONT + V_SYNC));
    origin    = (hc == '0) && (vc == '0);
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA scan-out: frame-buffer read port plus one registered output stage.
// Optional colour-bar generator enabled by VGA_CTRL_TEST_PATTERN_EN.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  output logic [31:0] rx,
  output logic [31:0] ry,
  output logic        ren,
  input  logic [31:0] rdata,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
`ifdef VGA_CTRL_TEST_PATTERN_EN
  ,
  input  logic        pattern_sel
`endif
);

  logic [CNT_W-1:0] hc, vc;
  logic             active, hsync_win, vsync_win, origin;
  logic             use_fb;
  rgb888_t          next_rgb, rgb_q;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clock     (clock),
    .reset     (reset),
    .pix_en    (pix_en),
    .hc        (hc),
    .vc        (vc),
    .active    (active),
    .hsync_win (hsync_win),
    .vsync_win (vsync_win),
    .origin    (origin)
  );

`ifdef VGA_CTRL_TEST_PATTERN_EN
  logic [2:0] bar_sel;

  always_comb begin
    bar_sel  = 3'(hc / CNT_W'(H_ACTIVE / 8));
    use_fb   = ~pattern_sel;
    next_rgb = pattern_sel ? BAR_COLOURS[bar_sel] : pixel_to_rgb(rdata);
  end
`else
  always_comb begin
    use_fb   = 1'b1;
    next_rgb = pixel_to_rgb(rdata);
  end
`endif

  always_comb begin
    ren = pix_en & active & use_fb;
    rx  = active ? 32'(hc) : '0;
    ry  = active ? 32'(vc) : '0;
  end

  // frame_start defaults low every clock so the pulse is one clock wide even when strobes are sparse.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b0;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        valid       <= active;
        rgb_q       <= active ? next_rgb : '0;
        hsync       <= ~hsync_win;
        vsync       <= ~vsync_win;
        frame_start <= origin;
      end
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- Scan-out (reader) side of the VGA frame buffer: generates 640x480-class raster timing, issues per-pixel reads (x, y, ren) to the frame-buffer read port, and drives registered RGB plus sync to the display model.
- Sits between the SoC frame buffer (CPU writes via the MMIO side) and the VGA display sink; runs on the single system clock, advancing one pixel per `pix_en` strobe.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CNT_W, 10, h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; counters and pipeline advance only when 1
- rx  out  32  read x (column), zero-extended
- ry  out  32  read y (row), zero-extended
- ren  out  1  read enable to frame buffer
- rdata  in  32  pixel 0x00RRGGBB, valid combinationally in the same cycle as ren
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- valid  out  1  1 when r/g/b carry a visible pixel
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- frame_start  out  1  one-cycle pulse when pixel (0,0) is presented on the outputs

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL likewise (525).
- Line order: active, front, sync, back. Active region is hc < H_ACTIVE and vc < V_ACTIVE.
- Counters hc, vc:
  - Reset to 0.
  - On pix_en, hc increments; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps to 0 at V_TOTAL-1 when hc also wraps.
  - When pix_en is 0, all state holds.
- Read stage (stage 0, combinational from counters):
  - ren = pix_en & active.
  - rx = hc, ry = vc.
  - When not active: ren = 0 and rx/ry = 0.
- Output stage (stage 1, registered on pix_en):
  - valid <= active.
  - {vga_r, vga_g, vga_b} <= active ? rdata[23:0] : 0.
  - hsync <= ~(hc in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]).
  - vsync <= ~(vc in the V sync window).
  - frame_start <= (hc==0 && vc==0); the pulse is cleared on the next clock whether or not pix_en is asserted.
- Latency:
  - Exactly 1 pix_en-cycle from counter value to outputs.
  - sync and colour are aligned because both pass through the same register.
- Reset values: hsync = 1, vsync = 1, valid = 0, rgb = 0, frame_start = 0, ren = 0.
- Reset mid-frame: on the next edge, counters return to (0,0) and outputs take their reset values. The first post-reset pix_en starts a full frame.
- rdata[31:24] is ignored. Counter arithmetic is unsigned CNT_W-bit with no overflow, given legal parameters.

Optional Feature:
- Macro: VGA_CTRL_TEST_PATTERN_EN.
- With the macro defined:
  - Adds input port `pattern_sel` (1 bit).
  - When pattern_sel = 1, ren is forced to 0 and the colour is eight vertical bars of width H_ACTIVE/8, from hc[bar index]: white, yellow, cyan, green, magenta, red, blue, black (each channel 0xFF/0x00).
  - Timing and latency are unchanged.
  - pattern_sel is sampled per pixel; switching mid-frame takes effect on the next pixel.
- Without the macro: no pattern_sel port; behaviour is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - Default timing localparams.
  - Typedef rgb888_t (struct r, g, b, 8 bits each).
  - Colour-bar constant array.
  - Function pixel_to_rgb(32-bit) -> rgb888_t.
- One natural sub-module: vga_timing_gen.
  - Contains the hc/vc counters, the active flag, and the raw sync windows.
  - vga_ctrl adds the read port and the output register stage.

Test Plan:
- Reset, then pix_en held 1 for one full frame (420000 cycles) -> per line: hsync low for exactly 96 cycles starting 1 cycle after hc=656; per frame: vsync low for exactly 2 lines (vc 490-491); exactly one frame_start pulse.
- Buffer model returns rdata = {8'h0, x[7:0], y[7:0], 8'hA5} -> at output pixel (5,3): rgb = 05,03,A5, valid = 1. At hc = 640, ren = 0; one cycle later valid = 0 and rgb = 0.
- pix_en toggling 1,0,1,0 -> counters and outputs advance only on strobe cycles; hsync width is still 96 strobes; frame_start pulse lasts exactly one clock.
- Assert reset at (hc=300, vc=200) for 1 cycle -> next cycle hsync = vsync = 1, valid = 0; next strobes read (0,0); frame_start follows one strobe later.
- Counter wrap: run to hc=799, vc=524 -> next strobe gives (0,0), ren = 1 at rx = ry = 0.
- With VGA_CTRL_TEST_PATTERN_EN defined and pattern_sel = 1 -> ren is never asserted; pixel x = 0 is FFFFFF, x = 80 is FFFF00, x = 639 is 000000.
